fifo_wptr_full: RTL

// Write-side controller for the async FIFO, one stage upstream of fifo_mem in the write clock domain.
// - Qualifies push requests into wr_en/wr_addr for fifo_mem.
// - Keeps the binary and Gray write pointers.
// - Synchronises the Gray read pointer in from the read domain.
// - Generates full, almost_full, a fill level and a sticky overflow flag.

---
 rtl/fifo_wptr_full.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain side of the async FIFO: push qualification, binary/Gray write pointers,
// read-pointer synchroniser, and full / almost_full / fill level / sticky overflow flags.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    input  logic                  ovf_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int              PW   = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   L_AF = PW'(AF_THRESH);

    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("fifo_wptr_full: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end
    if (ADDR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_param
        $error("fifo_wptr_full: ADDR_WIDTH or AF_THRESH out of range");
    end

    logic [PW-1:0] r_rq1;
    logic [PW-1:0] r_rq2;
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_full;
    logic          r_af;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    logic          w_push;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin_s;
    logic [PW-1:0] w_full_cmp;
    logic          w_full_next;
    logic [PW-1:0] w_level_next;
    logic          w_af_next;
    logic          w_ovf_next;

    // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
        assign w_rbin_s[gi] = ^(r_rq2 >> gi);
    end

    // Gating with rst_n keeps the memory strobe quiet while reset is held.
    assign w_push       = wr_req & ~r_full & rst_n;
    assign w_wbin_next  = r_wbin + PW'(w_push);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign w_full_cmp   = {~r_rq2[ADDR_WIDTH:ADDR_WIDTH-1], r_rq2[ADDR_WIDTH-2:0]};
    assign w_full_next  = (w_wgray_next == w_full_cmp);

    assign w_level_next = w_wbin_next - w_rbin_s;
    assign w_af_next    = (w_level_next >= L_AF);

    // Set has priority over clear so an overflow coinciding with a clear is not lost.
    assign w_ovf_next   = (wr_req & r_full) | (r_ovf & ~ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq1   <= '0;
            r_rq2   <= '0;
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_rq1   <= rd_ptr_gray;
            r_rq2   <= r_rq1;
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= w_full_next;
            r_af    <= w_af_next;
            r_level <= w_level_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign wr_en       = w_push;
    assign wr_addr     = r_wbin[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = r_wgray;
    assign full        = r_full;
    assign almost_full = r_af;
    assign wr_level    = r_level;
    assign overflow    = r_ovf;

endmodule
